// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-to-memory arbiter: state encoding,
// default bus widths and the grant identifiers used by the selector.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break).
package mem_arb_pkg;

    parameter int MEM_ARB_ADDR_W = 28;
    parameter int MEM_ARB_DATA_W = 128;

    // Grant identifiers shared by the selector and the top level
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-requester grant selector. D-cache beats I-cache by default; with
// MEM_ARB_RR_EN defined a tie goes to whichever cache was not granted last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic last_gnt,
`endif
    input  logic req_d,
    input  logic req_i,
    output logic valid,
    output logic gnt
);

    // Choose a grant ID from the current requests (and last grant when enabled)
    always_comb begin
        valid = req_d | req_i;
        gnt   = GNT_D;
        if (req_d && req_i) begin
`ifdef MEM_ARB_RR_EN
            gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
`else
            gnt = GNT_D;
`endif
        end else if (req_i) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache miss interfaces and the single
// shared block-wide memory port. One transfer at a time, followed by a
// one-cycle DRAIN that swallows the served cache's stale request tail.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t state;
    arb_state_t next_state;
    logic       d_pend;
    logic       i_pend;
    logic       any_pend;
    logic       gnt_id;
    logic       grant;

    assign d_pend   = d_read | d_write;
    assign i_pend   = i_read;
    assign grant    = (state == IDLE) && any_pend;

    // Read data goes to both caches; only the granted ready qualifies it
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_RR_EN
    logic last_gnt;

    // Remember who was granted most recently so ties alternate
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            last_gnt <= GNT_I;
        end else if (grant) begin
            last_gnt <= gnt_id;
        end
    end
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .last_gnt (last_gnt),
`endif
        .req_d    (d_pend),
        .req_i    (i_pend),
        .valid    (any_pend),
        .gnt      (gnt_id)
    );

    // State register
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and routing of mem_ready to the granted cache only
    always_comb begin
        next_state = state;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    next_state = (gnt_id == GNT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_ready    = 1'b1;
                    next_state = DRAIN;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    i_ready    = 1'b1;
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Memory-side outputs: captured on the grant edge, held while busy,
    // strobes cleared on the edge that ends the transfer
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        if (gnt_id == GNT_D) begin
                            mem_addr  <= d_addr;
                            mem_write <= d_write;
                            mem_read  <= ~d_write;
                            if (d_write) begin
                                mem_wdata <= d_wdata;
                            end
                        end else begin
                            mem_addr  <= i_addr;
                            mem_write <= 1'b0;
                            mem_read  <= 1'b1;
                        end
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          proc_reset;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int checkCount;
    int errorCount;

    localparam logic [DW-1:0] DATA_A = 128'hDEAD0000_11112222_33334444_0000BEEF;
    localparam logic [DW-1:0] DATA_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    mem_arbiter dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive the request and memory-handshake strobes
    task automatic applyStimulus(input logic ir, input logic dr, input logic dw,
                                 input logic mr);
        i_read    = ir;
        d_read    = dr;
        d_write   = dw;
        mem_ready = mr;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence
    initial begin
        checkCount = 0;
        errorCount = 0;
        proc_reset = 1'b1;
        i_addr     = '0;
        d_addr     = '0;
        d_wdata    = '0;
        mem_rdata  = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #2;
        checkOutput("rst_mem_read", DW'(mem_read), DW'(1'b0));
        checkOutput("rst_mem_write", DW'(mem_write), DW'(1'b0));
        checkOutput("rst_mem_addr", DW'(mem_addr), '0);
        checkOutput("rst_mem_wdata", mem_wdata, '0);
        checkOutput("rst_i_ready", DW'(i_ready), DW'(1'b0));
        checkOutput("rst_d_ready", DW'(d_ready), DW'(1'b0));
        #10 proc_reset = 1'b0;
        tick();

        // I-only read, memory answers three cycles after the strobe rises
        i_addr = 28'h0000010;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("i_pre_strobe", DW'(mem_read), DW'(1'b0));
        tick();
        checkOutput("i_mem_read", DW'(mem_read), DW'(1'b1));
        checkOutput("i_mem_write", DW'(mem_write), DW'(1'b0));
        checkOutput("i_mem_addr", DW'(mem_addr), DW'(28'h0000010));
        tick();
        tick();
        checkOutput("i_wait_ready", DW'(i_ready), DW'(1'b0));
        mem_rdata = DATA_A;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("i_ready", DW'(i_ready), DW'(1'b1));
        checkOutput("i_rdata", i_rdata, DATA_A);
        checkOutput("i_d_ready_low", DW'(d_ready), DW'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("i_drain_read", DW'(mem_read), DW'(1'b0));
        checkOutput("i_drain_ready", DW'(i_ready), DW'(1'b0));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("i_tail_ignored", DW'(mem_read), DW'(1'b0));

        // Simultaneous reads: D first, I re-arbitrated two cycles after d_ready
        i_addr = 28'h0000020;
        d_addr = 28'h0000030;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("both_first_addr", DW'(mem_addr), DW'(28'h0000030));
        checkOutput("both_first_read", DW'(mem_read), DW'(1'b1));
        mem_rdata = DATA_B;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("both_d_ready", DW'(d_ready), DW'(1'b1));
        checkOutput("both_d_rdata", d_rdata, DATA_B);
        checkOutput("both_i_ready_low", DW'(i_ready), DW'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("both_drain_read", DW'(mem_read), DW'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("both_idle_read", DW'(mem_read), DW'(1'b0));
        tick();
        checkOutput("both_second_addr", DW'(mem_addr), DW'(28'h0000020));
        checkOutput("both_second_read", DW'(mem_read), DW'(1'b1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("both_i_ready", DW'(i_ready), DW'(1'b1));
        checkOutput("both_d_ready_low", DW'(d_ready), DW'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // D write-back followed by a refill at a new address
        d_addr  = 28'h0000123;
        d_wdata = 128'h1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("wb_mem_write", DW'(mem_write), DW'(1'b1));
        checkOutput("wb_mem_read", DW'(mem_read), DW'(1'b0));
        checkOutput("wb_mem_addr", DW'(mem_addr), DW'(28'h0000123));
        checkOutput("wb_mem_wdata", mem_wdata, 128'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("wb_d_ready", DW'(d_ready), DW'(1'b1));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("wb_drain_write", DW'(mem_write), DW'(1'b0));
        tick();
        d_addr = 28'h0000456;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("refill_read", DW'(mem_read), DW'(1'b1));
        checkOutput("refill_no_write", DW'(mem_write), DW'(1'b0));
        checkOutput("refill_addr", DW'(mem_addr), DW'(28'h0000456));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        // Stale D tail held through DRAIN only: no new strobe afterwards
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("tail_no_strobe1", DW'(mem_read), DW'(1'b0));
        tick();
        checkOutput("tail_no_strobe2", DW'(mem_read), DW'(1'b0));

        // Spurious ready in IDLE is ignored and the arbiter stays IDLE
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("spur_i_ready", DW'(i_ready), DW'(1'b0));
        checkOutput("spur_d_ready", DW'(d_ready), DW'(1'b0));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal read+write: write wins; a one-cycle grant proves we were IDLE
        d_addr  = 28'h0000777;
        d_wdata = DATA_B;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rw_mem_write", DW'(mem_write), DW'(1'b1));
        checkOutput("rw_mem_read", DW'(mem_read), DW'(1'b0));
        checkOutput("rw_mem_wdata", mem_wdata, DATA_B);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        // Tie after a D grant: fixed priority picks D, round-robin picks I
        i_addr = 28'h0000A0A;
        d_addr = 28'h0000B0B;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef MEM_ARB_RR_EN
        checkOutput("tie_after_d_addr", DW'(mem_addr), DW'(28'h0000A0A));
`else
        checkOutput("tie_after_d_addr", DW'(mem_addr), DW'(28'h0000B0B));
`endif
        checkOutput("tie_after_d_read", DW'(mem_read), DW'(1'b1));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset between edges while an I read is in flight
        i_addr = 28'h0000CCC;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rbusy_read_up", DW'(mem_read), DW'(1'b1));
        #2 proc_reset = 1'b1;
        #1;
        checkOutput("rbusy_async_drop", DW'(mem_read), DW'(1'b0));
        checkOutput("rbusy_addr_clr", DW'(mem_addr), '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        proc_reset = 1'b0;
        tick();
        checkOutput("rbusy_idle_read", DW'(mem_read), DW'(1'b0));
        i_addr = 28'h0000111;
        d_addr = 28'h0000222;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("rbusy_rearb_addr", DW'(mem_addr), DW'(28'h0000222));
        checkOutput("rbusy_rearb_read", DW'(mem_read), DW'(1'b1));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("rbusy_d_ready", DW'(d_ready), DW'(1'b1));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
